// File: rtl/sdlx_mc_core.sv
// sdlx_mc_core: multi-cycle SDLX processor core.
// One instruction is sequenced through FETCH, DECODE, EXEC, MEM and WB.
// The core talks to separate instruction and data memories over req/ack
// handshakes. A req stays high, with stable address, data and we, until
// its ack arrives. At most one of the two requests is high in any cycle.
module sdlx_mc_core #(
    parameter int              DATA_W   = 32,
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [PC_W-1:0]   dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [PC_W-1:0]   pc_out,
    output logic              retire,
    output logic              halted,
    output logic              illegal
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQZ  = 6'h04;
    localparam logic [5:0] OP_BNEZ  = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // Architectural and sequencing state
    state_t                    state_q, state_d;
    logic [PC_W-1:0]           pc_q, pc_d;
    logic [31:0]               ir_q, ir_d;
    logic signed [DATA_W-1:0]  a_q, a_d;
    logic signed [DATA_W-1:0]  b_q, b_d;
    logic [DATA_W-1:0]         alu_q, alu_d;
    logic [DATA_W-1:0]         mdr_q, mdr_d;
    logic                      illegal_q, illegal_d;
    logic [DATA_W-1:0]         regs_q [32];
    logic [DATA_W-1:0]         regs_d [32];

    // Instruction fields, always taken from the latched IR
    logic [5:0]               op;
    logic [5:0]               func;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [4:0]               rd;
    logic signed [DATA_W-1:0] imm16_ext;
    logic [PC_W-1:0]          br_off;
    logic [PC_W-1:0]          pc_inc;
    logic [PC_W-1:0]          br_target;
    logic                     br_taken;
    logic [DATA_W-1:0]        wb_data;

    logic is_rtype;
    logic is_legal;
    logic is_halt;
    logic is_branch;
    logic is_load;
    logic is_store;

    assign op        = ir_q[31:26];
    assign func      = ir_q[5:0];
    assign rs1       = ir_q[25:21];
    assign rs2       = ir_q[20:16];
    assign rd        = is_rtype ? ir_q[15:11] : ir_q[20:16];
    assign imm16_ext = DATA_W'($signed(ir_q[15:0]));

    // J uses the 26-bit offset, conditional branches the 16-bit one.
    // The target wraps modulo 2^PC_W.
    assign br_off    = (op == OP_J) ? PC_W'($signed(ir_q[25:0]))
                                    : PC_W'($signed(ir_q[15:0]));
    assign pc_inc    = pc_q + PC_W'(1);
    assign br_target = pc_inc + br_off;
    assign br_taken  = (op == OP_J)    ? 1'b1 :
                       (op == OP_BEQZ) ? (a_q == '0) :
                                         (a_q != '0);
    assign wb_data   = is_load ? mdr_q : alu_q;

    // All ALU work: R-type by function code, otherwise rs1 + imm16
    // (ADDI and the LW/SW address). Arithmetic wraps with no trap.
    function automatic logic [DATA_W-1:0] alu_f(
        input logic                     rtype,
        input logic [5:0]               fn,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b,
        input logic signed [DATA_W-1:0] imm
    );
        logic [DATA_W-1:0] res;
        res = a + imm;
        if (rtype) begin
            case (fn)
                FN_ADD:  res = a + b;
                FN_SUB:  res = a - b;
                FN_AND:  res = a & b;
                FN_OR:   res = a | b;
                FN_SLT:  res = (a < b) ? DATA_W'(1) : '0;
                default: res = '0;
            endcase
        end
        return res;
    endfunction

    // Decode the latched opcode and function into instruction classes
    always_comb begin
        is_rtype  = 1'b0;
        is_legal  = 1'b1;
        is_halt   = 1'b0;
        is_branch = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        case (op)
            OP_RTYPE: begin
                is_rtype = 1'b1;
                case (func)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: is_legal = 1'b1;
                    default:                               is_legal = 1'b0;
                endcase
            end
            OP_ADDI:                is_legal  = 1'b1;
            OP_LW:                  is_load   = 1'b1;
            OP_SW:                  is_store  = 1'b1;
            OP_BEQZ, OP_BNEZ, OP_J: is_branch = 1'b1;
            OP_HALT:                is_halt   = 1'b1;
            default:                is_legal  = 1'b0;
        endcase
    end

    // Next-state logic: sequence one instruction per trip around the FSM
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        illegal_d = illegal_q;
        regs_d    = regs_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // r0 is never written, so reading it always gives zero
                a_d = regs_q[rs1];
                b_d = regs_q[rs2];
                if (!is_legal) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_d = alu_f(is_rtype, func, a_q, b_q, imm16_ext);
                if (is_branch) begin
                    pc_d    = br_taken ? br_target : pc_inc;
                    state_d = S_FETCH;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (is_store) begin
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end else begin
                        mdr_d   = dmem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                if (rd != 5'd0) begin
                    regs_d[rd] = wb_data;
                end
                pc_d    = pc_inc;
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State registers, including the register file, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            mdr_q     <= '0;
            illegal_q <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_q     <= alu_d;
            mdr_q     <= mdr_d;
            illegal_q <= illegal_d;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Outputs decoded from state. Requests are gated by rst so that they
    // are low for the whole time reset is held, not just after the edge.
    always_comb begin
        imem_req   = !rst && (state_q == S_FETCH);
        dmem_req   = !rst && (state_q == S_MEM);
        dmem_we    = !rst && (state_q == S_MEM) && is_store;
        retire     = !rst && (((state_q == S_EXEC) && is_branch) ||
                              ((state_q == S_MEM) && is_store && dmem_ack) ||
                              (state_q == S_WB));
        halted     = (state_q == S_HALT);
        illegal    = illegal_q;
        imem_addr  = pc_q;
        pc_out     = pc_q;
        dmem_addr  = alu_q[PC_W-1:0];
        dmem_wdata = b_q;
    end

endmodule

// File: tb/tb_sdlx_mc_core.sv
// Testbench for sdlx_mc_core: directed program with hand-computed results,
// plus reset-state, halt and reset-during-data-access cases.
module tb_sdlx_mc_core;
    localparam int              DATA_W = 32;
    localparam int              PC_W   = 16;
    localparam logic [PC_W-1:0] RST_PC = 16'h0010;

    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQZ = 6'h04;
    localparam logic [5:0] OP_BNEZ = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_HALT = 6'h3F;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic [31:0]       imem_rdata;
    logic              imem_ack;
    logic              dmem_req;
    logic              dmem_we;
    logic [PC_W-1:0]   dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;
    logic [PC_W-1:0]   pc_out;
    logic              retire;
    logic              halted;
    logic              illegal;

    // Memory models
    logic [31:0] imem [0:63];
    int          idly [0:63];
    logic [31:0] dmem [0:127];
    int          icnt = 0;
    int          dcnt = 0;
    int          ddly = 0;
    logic        dforce = 1'b0;

    // Observation logs
    int          cyc = 0;
    int          ret_n = 0;
    int          f_n = 0;
    int          t_n = 0;
    int          ret_cyc [0:63];
    logic [15:0] f_addr  [0:63];
    logic [15:0] t_addr  [0:15];
    logic        t_we    [0:15];
    logic [31:0] t_wdata [0:15];

    int n_vec = 0;
    int n_err = 0;

    sdlx_mc_core #(
        .DATA_W   (DATA_W),
        .PC_W     (PC_W),
        .RESET_PC (RST_PC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .pc_out     (pc_out),
        .retire     (retire),
        .halted     (halted),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    assign imem_rdata = imem[imem_addr[5:0]];
    assign imem_ack   = imem_req && (icnt >= idly[imem_addr[5:0]]);
    assign dmem_rdata = dmem[dmem_addr[6:0]];
    assign dmem_ack   = dforce || (dmem_req && (dcnt >= ddly));

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            icnt <= 0;
            dcnt <= 0;
        end else begin
            icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
            dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
        end
    end

    always @(posedge clk) begin
        if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr[6:0]] <= dmem_wdata;
    end

    // Log retires (with cycle number since reset release), fetches and data accesses
    always @(negedge clk) begin
        if (rst) begin
            cyc <= 0;
        end else begin
            cyc <= cyc + 1;
            if (retire && ret_n < 64) begin
                ret_cyc[ret_n] <= cyc + 1;
                ret_n          <= ret_n + 1;
            end
            if (imem_req && imem_ack && f_n < 64) begin
                f_addr[f_n] <= imem_addr;
                f_n         <= f_n + 1;
            end
            if (dmem_req && dmem_ack && t_n < 16) begin
                t_addr[t_n]  <= dmem_addr;
                t_we[t_n]    <= dmem_we;
                t_wdata[t_n] <= dmem_wdata;
                t_n          <= t_n + 1;
            end
        end
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] off);
        return {op, off};
    endfunction

    task automatic wait_halt(input string tag);
        for (int k = 0; k < 3000 && !halted; k++) @(negedge clk);
        check_vec(tag, {31'd0, halted}, 32'd1);
    endtask

    logic [15:0] exp_f [0:25];
    logic [15:0] exp_ta [0:7];
    logic        exp_tw [0:7];
    logic [31:0] exp_td [0:7];

    initial begin
        logic any_req;
        for (int i = 0; i < 64; i++) begin
            imem[i] = 32'h0;
            idly[i] = 0;
        end
        // Main program
        imem[6'h10] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5);
        imem[6'h11] = enc_i(OP_ADDI, 5'd0, 5'd2, 16'd7);
        imem[6'h12] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);          // ADD r3
        imem[6'h13] = enc_r(5'd1, 5'd2, 5'd4, 6'h22);          // SUB r4
        imem[6'h14] = enc_r(5'd4, 5'd1, 5'd5, 6'h2A);          // SLT r5
        imem[6'h15] = enc_i(OP_ADDI, 5'd0, 5'd0, 16'd9);       // r0 write
        imem[6'h16] = enc_i(OP_SW, 5'd0, 5'd3, 16'h0040);
        imem[6'h17] = enc_i(OP_SW, 5'd0, 5'd4, 16'h0041);
        imem[6'h18] = enc_i(OP_SW, 5'd0, 5'd5, 16'h0042);
        imem[6'h19] = enc_i(OP_SW, 5'd0, 5'd0, 16'h0043);
        imem[6'h1A] = enc_i(OP_SW, 5'd0, 5'd3, 16'h0004);
        imem[6'h1B] = enc_i(OP_LW, 5'd0, 5'd6, 16'h0004);
        imem[6'h1C] = enc_i(OP_SW, 5'd0, 5'd6, 16'h0044);
        imem[6'h1D] = enc_i(OP_BEQZ, 5'd1, 5'd0, 16'd10);      // not taken
        imem[6'h1E] = enc_j(OP_J, 26'h0000011);                // -> 0x30
        imem[6'h30] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd3);
        imem[6'h31] = enc_i(OP_ADDI, 5'd1, 5'd1, 16'hFFFF);
        imem[6'h32] = enc_i(OP_BNEZ, 5'd1, 5'd0, 16'hFFFE);    // -> 0x31
        imem[6'h33] = enc_i(OP_BEQZ, 5'd1, 5'd0, 16'd1);       // -> 0x35
        imem[6'h35] = enc_i(OP_SW, 5'd0, 5'd1, 16'h0045);
        imem[6'h36] = enc_j(OP_J, 26'h3FFFFE9);                // -> 0x20
        imem[6'h20] = 32'hF800_0000;                           // opcode 0x3E
        idly[6'h1A] = 2;
        idly[6'h1B] = 2;

        for (int i = 0; i < 15; i++) exp_f[i] = 16'h0010 + 16'(i);
        exp_f[15] = 16'h30; exp_f[16] = 16'h31; exp_f[17] = 16'h32;
        exp_f[18] = 16'h31; exp_f[19] = 16'h32; exp_f[20] = 16'h31;
        exp_f[21] = 16'h32; exp_f[22] = 16'h33; exp_f[23] = 16'h35;
        exp_f[24] = 16'h36; exp_f[25] = 16'h20;

        exp_ta = '{16'h40, 16'h41, 16'h42, 16'h43, 16'h04, 16'h04, 16'h44, 16'h45};
        exp_tw = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        exp_td = '{32'd12, 32'hFFFF_FFFE, 32'd1, 32'd0, 32'd12, 32'd0, 32'd12, 32'd0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_vec("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check_vec("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        check_vec("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
        check_vec("rst_retire", {31'd0, retire}, 32'd0);
        check_vec("rst_halted", {31'd0, halted}, 32'd0);
        check_vec("rst_illegal", {31'd0, illegal}, 32'd0);
        check_vec("rst_imem_addr", {16'd0, imem_addr}, 32'h10);
        check_vec("rst_dmem_addr", {16'd0, dmem_addr}, 32'h0);
        check_vec("rst_dmem_wdata", dmem_wdata, 32'h0);
        check_vec("rst_pc_out", {16'd0, pc_out}, 32'h10);
        rst = 1'b0;
        @(negedge clk);
        check_vec("first_fetch_addr", {16'd0, imem_addr}, 32'h10);
        check_vec("first_fetch_req", {31'd0, imem_req}, 32'd1);

        // Run main program to the illegal opcode
        wait_halt("p1_halt_reached");
        check_vec("p1_illegal", {31'd0, illegal}, 32'd1);
        check_vec("p1_pc_out", {16'd0, pc_out}, 32'h20);
        any_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            any_req = any_req | imem_req | dmem_req;
        end
        check_vec("p1_no_req_in_halt", {31'd0, any_req}, 32'd0);
        check_vec("p1_pc_frozen", {16'd0, pc_out}, 32'h20);
        check_vec("p1_retire_count", ret_n, 25);
        check_vec("ret_add1", ret_cyc[0], 4);
        check_vec("ret_add2", ret_cyc[1], 8);
        check_vec("ret_add3", ret_cyc[2], 12);
        check_vec("ret_sw_wait", ret_cyc[10], 46);
        check_vec("ret_lw_wait", ret_cyc[11], 53);
        check_vec("ret_beqz", ret_cyc[13], 60);
        check_vec("p1_fetch_count", f_n, 26);
        for (int i = 0; i < 26; i++)
            check_vec($sformatf("fetch_%0d", i), {16'd0, f_addr[i]}, {16'd0, exp_f[i]});
        check_vec("p1_txn_count", t_n, 8);
        for (int i = 0; i < 8; i++) begin
            check_vec($sformatf("txn_addr_%0d", i), {16'd0, t_addr[i]}, {16'd0, exp_ta[i]});
            check_vec($sformatf("txn_we_%0d", i), {31'd0, t_we[i]}, {31'd0, exp_tw[i]});
            if (exp_tw[i])
                check_vec($sformatf("txn_wdata_%0d", i), t_wdata[i], exp_td[i]);
        end

        // Reset during a stalled data access
        @(posedge clk);
        #1 rst = 1'b1;
        ddly = 1000;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 200 && !dmem_req; k++) @(negedge clk);
        check_vec("p2_mem_wait_reached", {31'd0, dmem_req}, 32'd1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_vec("p2_async_dmem_req", {31'd0, dmem_req}, 32'd0);
        check_vec("p2_async_imem_req", {31'd0, imem_req}, 32'd0);
        dforce = 1'b1;
        ddly = 0;
        imem[6'h10] = enc_i(OP_SW, 5'd0, 5'd3, 16'h0046);
        imem[6'h11] = enc_i(OP_HALT, 5'd0, 5'd0, 16'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_vec("p2_restart_addr", {16'd0, imem_addr}, 32'h10);
        check_vec("p2_restart_imem_req", {31'd0, imem_req}, 32'd1);
        check_vec("p2_restart_dmem_req", {31'd0, dmem_req}, 32'd0);
        @(posedge clk);
        #1 dforce = 1'b0;
        wait_halt("p2_halt_reached");
        check_vec("p2_illegal_clear", {31'd0, illegal}, 32'd0);
        check_vec("p2_pc_out", {16'd0, pc_out}, 32'h11);
        check_vec("p2_txn_count", t_n, 9);
        check_vec("p2_txn_addr", {16'd0, t_addr[8]}, 32'h46);
        check_vec("p2_txn_we", {31'd0, t_we[8]}, 32'd1);
        check_vec("p2_reg_cleared", t_wdata[8], 32'd0);
        @(negedge clk);
        check_vec("p2_no_req_in_halt", {30'd0, imem_req, dmem_req}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
